// File: rtl/motor_fault_recovery_if.sv
// Sense/command/status bundle between the motor fault supervisor and its
// surroundings (sense pins, clear command, bridge enables, PWM duty ceiling).
interface motor_fault_recovery_if;
  logic       OCA;
  logic       OCB;
  logic       clear_fault;
  logic       ENA;
  logic       ENB;
  logic [7:0] duty_limit;
  logic       overcurrent;
  logic       lockout;
  logic [2:0] retry_count;

  modport master (
    output OCA, OCB, clear_fault,
    input  ENA, ENB, duty_limit, overcurrent, lockout, retry_count
  );

  modport slave (
    input  OCA, OCB, clear_fault,
    output ENA, ENB, duty_limit, overcurrent, lockout, retry_count
  );
endinterface

// File: rtl/motor_fault_recovery.sv
// Overcurrent supervisor for both H-bridge channels: qualifies the active-low
// sense pins, trips both enables, cools down, soft-starts the duty ceiling and
// latches a lockout after too many retries until an explicit clear.
module motor_fault_recovery #(
  parameter int unsigned QUAL_CYCLES      = 1_000_000,
  parameter int unsigned COOLDOWN_CYCLES  = 50_000_000,
  parameter int unsigned RAMP_STEP_CYCLES = 10_000,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned STABLE_CYCLES    = 100_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  motor_fault_recovery_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN,
    S_QUALIFY,
    S_COOLDOWN,
    S_RAMP,
    S_LOCKOUT
  } state_t;

  localparam logic [26:0] QUAL_LAST   = 27'(QUAL_CYCLES - 1);
  localparam logic [26:0] COOL_LAST   = 27'(COOLDOWN_CYCLES - 1);
  localparam logic [26:0] STEP_LAST   = 27'(RAMP_STEP_CYCLES - 1);
  localparam logic [26:0] STABLE_LAST = 27'(STABLE_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX   = 3'(MAX_RETRIES);

  logic        ocaMeta_q;
  logic        ocaSync_q;
  logic        ocbMeta_q;
  logic        ocbSync_q;
  logic        fault;

  state_t      state_q;
  state_t      retState_q;
  logic [26:0] qualCnt_q;
  logic [26:0] coolCnt_q;
  logic [26:0] stepCnt_q;
  logic [26:0] stableCnt_q;
  logic [2:0]  retry_q;
  logic        enable_q;
  logic [7:0]  duty_q;
  logic        overcurrent_q;
  logic        lockout_q;

  // Two-flop synchronizers for the asynchronous sense pins; idle level is high.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      ocaMeta_q <= 1'b1;
      ocaSync_q <= 1'b1;
      ocbMeta_q <= 1'b1;
      ocbSync_q <= 1'b1;
    end else begin
      ocaMeta_q <= bus.OCA;
      ocaSync_q <= ocaMeta_q;
      ocbMeta_q <= bus.OCB;
      ocbSync_q <= ocbMeta_q;
    end
  end

  // Either channel pulling its sense pin low counts as a fault on both.
  assign fault = ~ocaSync_q | ~ocbSync_q;

  // Supervisor FSM with registered outputs; outputs change only on transitions
  // (or ramp steps), so QUALIFY naturally holds whatever its return state drove.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q       <= S_RUN;
      retState_q    <= S_RUN;
      qualCnt_q     <= '0;
      coolCnt_q     <= '0;
      stepCnt_q     <= '0;
      stableCnt_q   <= '0;
      retry_q       <= '0;
      enable_q      <= 1'b1;
      duty_q        <= 8'hFF;
      overcurrent_q <= 1'b0;
      lockout_q     <= 1'b0;
    end else begin
      stableCnt_q <= '0;
      case (state_q)
        S_RUN: begin
          if (fault) begin
            state_q    <= S_QUALIFY;
            retState_q <= S_RUN;
            qualCnt_q  <= '0;
          end else if (stableCnt_q == STABLE_LAST) begin
            retry_q <= '0;
          end else begin
            stableCnt_q <= stableCnt_q + 27'd1;
          end
        end

        S_QUALIFY: begin
          if (!fault) begin
            state_q   <= retState_q;
            qualCnt_q <= '0;
          end else if (qualCnt_q == QUAL_LAST) begin
            qualCnt_q     <= '0;
            coolCnt_q     <= '0;
            stepCnt_q     <= '0;
            enable_q      <= 1'b0;
            duty_q        <= 8'h00;
            overcurrent_q <= 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_q   <= S_LOCKOUT;
              lockout_q <= 1'b1;
            end else begin
              state_q <= S_COOLDOWN;
              retry_q <= retry_q + 3'd1;
            end
          end else begin
            qualCnt_q <= qualCnt_q + 27'd1;
          end
        end

        S_COOLDOWN: begin
          if (coolCnt_q == COOL_LAST) begin
            coolCnt_q <= '0;
            if (!fault) begin
              state_q       <= S_RAMP;
              enable_q      <= 1'b1;
              duty_q        <= 8'h00;
              overcurrent_q <= 1'b0;
              stepCnt_q     <= '0;
            end
          end else begin
            coolCnt_q <= coolCnt_q + 27'd1;
          end
        end

        S_RAMP: begin
          if (fault) begin
            state_q    <= S_QUALIFY;
            retState_q <= S_RAMP;
            qualCnt_q  <= '0;
          end else if (duty_q == 8'hFF) begin
            state_q <= S_RUN;
          end else if (stepCnt_q == STEP_LAST) begin
            stepCnt_q <= '0;
            duty_q    <= duty_q + 8'd1;
          end else begin
            stepCnt_q <= stepCnt_q + 27'd1;
          end
        end

        S_LOCKOUT: begin
          if (bus.clear_fault && !fault) begin
            state_q       <= S_RAMP;
            retry_q       <= '0;
            lockout_q     <= 1'b0;
            overcurrent_q <= 1'b0;
            enable_q      <= 1'b1;
            duty_q        <= 8'h00;
            stepCnt_q     <= '0;
          end
        end

        default: begin
          state_q       <= S_RUN;
          retState_q    <= S_RUN;
          qualCnt_q     <= '0;
          coolCnt_q     <= '0;
          stepCnt_q     <= '0;
          enable_q      <= 1'b1;
          duty_q        <= 8'hFF;
          overcurrent_q <= 1'b0;
          lockout_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ENA         = enable_q;
  assign bus.ENB         = enable_q;
  assign bus.duty_limit  = duty_q;
  assign bus.overcurrent = overcurrent_q;
  assign bus.lockout     = lockout_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_motor_fault_recovery.sv
// Directed scoreboard bench for motor_fault_recovery with shortened timing
// parameters; expected output snapshots are queued as stimulus is applied.
module tb_motor_fault_recovery;

  localparam int unsigned QUAL   = 4;
  localparam int unsigned COOL   = 20;
  localparam int unsigned STEP   = 2;
  localparam int unsigned MAXR   = 2;
  localparam int unsigned STABLE = 50;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } expItem_t;

  logic clk = 1'b0;
  logic reset;
  expItem_t expQ[$];
  int vectorsApplied = 0;
  int miscompares = 0;

  motor_fault_recovery_if bus ();

  motor_fault_recovery #(
    .QUAL_CYCLES      (QUAL),
    .COOLDOWN_CYCLES  (COOL),
    .RAMP_STEP_CYCLES (STEP),
    .MAX_RETRIES      (MAXR),
    .STABLE_CYCLES    (STABLE)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hang guard in case the run never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] vec(input logic en, input logic [7:0] duty,
                                      input logic oc, input logic lk,
                                      input logic [2:0] rc);
    return {1'b0, en, en, oc, lk, rc, duty};
  endfunction

  function automatic logic [15:0] obs();
    return {1'b0, bus.ENA, bus.ENB, bus.overcurrent, bus.lockout,
            bus.retry_count, bus.duty_limit};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic oca, input logic ocb, input logic clr);
    bus.OCA         = oca;
    bus.OCB         = ocb;
    bus.clear_fault = clr;
  endtask

  task automatic pushExp(input string tag, input logic [15:0] e);
    expItem_t it;
    it.tag = tag;
    it.exp = e;
    expQ.push_back(it);
  endtask

  task automatic checkOutput(input logic [15:0] observed);
    expItem_t it;
    vectorsApplied++;
    if (expQ.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<queued entry>", observed);
    end else begin
      it = expQ.pop_front();
      assert (observed === it.exp)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%h expected=%h", it.tag, observed, it.exp);
      end
    end
  endtask

  // Directed scenario sequence.
  initial begin
    logic [15:0] flags;

    applyStimulus(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    pushExp("reset_state", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(3);
    checkOutput(obs());
    reset = 1'b0;
    cycles(2);

    // Glitch shorter than the qualify window.
    applyStimulus(1'b0, 1'b1, 1'b0);
    flags = '0;
    pushExp("glitch_no_trip", 16'h0000);
    for (int i = 0; i < 15; i++) begin
      cycles(1);
      flags = flags | {13'b0, bus.overcurrent, ~bus.ENA, ~bus.ENB};
      if (i == 2) applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput(flags);
    pushExp("glitch_final", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    checkOutput(obs());

    // Single qualified trip, cooldown, full ramp, then stable clear.
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushExp("trip_pre", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(6);
    checkOutput(obs());
    pushExp("trip_fall", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());
    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp("cool_hold", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd1));
    cycles(16);
    checkOutput(obs());
    pushExp("ramp_start", vec(1'b1, 8'd0, 1'b0, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());
    pushExp("ramp_254", vec(1'b1, 8'd254, 1'b0, 1'b0, 3'd1));
    cycles(509);
    checkOutput(obs());
    pushExp("ramp_255", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());
    pushExp("stable_hold", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd1));
    cycles(50);
    checkOutput(obs());
    pushExp("stable_clear", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(1);
    checkOutput(obs());

    // Three trips without a stable period end in lockout.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp("lk_trip1", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd1));
    cycles(7);
    checkOutput(obs());
    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp("lk_ramp1", vec(1'b1, 8'd0, 1'b0, 1'b0, 3'd1));
    cycles(17);
    checkOutput(obs());
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp("lk_trip2", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd2));
    cycles(7);
    checkOutput(obs());
    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp("lk_ramp2", vec(1'b1, 8'd0, 1'b0, 1'b0, 3'd2));
    cycles(17);
    checkOutput(obs());
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp("lk_lock", vec(1'b0, 8'd0, 1'b1, 1'b1, 3'd2));
    cycles(7);
    checkOutput(obs());
    cycles(3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    pushExp("lk_clear_blocked", vec(1'b0, 8'd0, 1'b1, 1'b1, 3'd2));
    cycles(1);
    checkOutput(obs());
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycles(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExp("lk_clear", vec(1'b1, 8'd0, 1'b0, 1'b0, 3'd0));
    cycles(1);
    checkOutput(obs());
    applyStimulus(1'b1, 1'b1, 1'b0);

    // Qualified fault while the ramp sits at 40: ramp freezes, then trips.
    pushExp("frz_39", vec(1'b1, 8'd39, 1'b0, 1'b0, 3'd0));
    cycles(78);
    checkOutput(obs());
    cycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp("frz_a", vec(1'b1, 8'd40, 1'b0, 1'b0, 3'd0));
    cycles(3);
    checkOutput(obs());
    pushExp("frz_b", vec(1'b1, 8'd40, 1'b0, 1'b0, 3'd0));
    cycles(3);
    checkOutput(obs());
    pushExp("frz_trip", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());
    cycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp("frz_ramp", vec(1'b1, 8'd0, 1'b0, 1'b0, 3'd1));
    cycles(17);
    checkOutput(obs());

    // Short fault at 40 during the ramp: held, then resumes from 40.
    pushExp("glt_39", vec(1'b1, 8'd39, 1'b0, 1'b0, 3'd1));
    cycles(78);
    checkOutput(obs());
    cycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycles(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp("glt_hold", vec(1'b1, 8'd40, 1'b0, 1'b0, 3'd1));
    cycles(2);
    checkOutput(obs());
    pushExp("glt_back", vec(1'b1, 8'd40, 1'b0, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());
    pushExp("glt_resume", vec(1'b1, 8'd41, 1'b0, 1'b0, 3'd1));
    cycles(1);
    checkOutput(obs());

    // Reset in the middle of COOLDOWN.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp("rst_cool", vec(1'b0, 8'd0, 1'b1, 1'b0, 3'd2));
    cycles(7);
    checkOutput(obs());
    cycles(5);
    reset = 1'b1;
    pushExp("rst_apply", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(1);
    checkOutput(obs());
    applyStimulus(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    pushExp("rst_after", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(10);
    checkOutput(obs());

    // clear_fault outside LOCKOUT has no effect.
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExp("clr_run", vec(1'b1, 8'd255, 1'b0, 1'b0, 3'd0));
    cycles(1);
    checkOutput(obs());
    applyStimulus(1'b1, 1'b1, 1'b0);
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
